// File: rtl/spi_bus_sniffer.sv
// rtl/spi_bus_sniffer.sv - passive SPI bus monitor capturing MOSI/MISO frames into a FIFO
// Bus pins are oversampled in the clk_12 domain; the bus is never driven.
module spi_bus_sniffer #(
  parameter int FRAME_LEN   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_12,
  input  logic                 rstn,
  input  logic                 sclk,
  input  logic                 MISO,
  input  logic                 MOSI,
  input  logic                 SS,
  input  logic [1:0]           mode,
  input  logic                 rd_en,
  input  logic                 clr_flags,
  output logic [FRAME_LEN-1:0] dout_mosi,
  output logic [FRAME_LEN-1:0] dout_miso,
  output logic                 dout_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [1:0]                  hist_q;
  logic                        ss_s, sclk_s, mosi_s, miso_s;
  logic                        ss_fall, ss_rise, sclk_rise, sclk_fall, sample_edge;

  logic [1:0]           mode_q;
  logic [FRAME_LEN-1:0] sh_mosi, sh_miso;
  logic [CW-1:0]        bit_cnt;
  logic                 push_q;
  logic                 start, stop, shift_en, frame_done, abort_set;

  logic [2*FRAME_LEN-1:0] mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   do_pop, do_push, overflow_set;

  // Packed as {SS, sclk, MOSI, MISO}; stage 0 is the pin-side flop.
  always_ff @(posedge clk_12 or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {SS, sclk, MOSI, MISO}};
      hist_q <= {ss_s, sclk_s};
    end
  end

  assign {ss_s, sclk_s, mosi_s, miso_s} = sync_q[SYNC_STAGES-1];
  assign ss_fall   = hist_q[1] & ~ss_s;
  assign ss_rise   = ~hist_q[1] & ss_s;
  assign sclk_rise = sclk_s & ~hist_q[0];
  assign sclk_fall = ~sclk_s & hist_q[0];
  // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising edge.
  assign sample_edge = (mode_q[1] ^ mode_q[0]) ? sclk_fall : sclk_rise;

  always_ff @(posedge clk_12 or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    stop       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    abort_set  = 1'b0;
    case (state)
      IDLE: start = ss_fall;
      SHIFT: begin
        if (ss_rise) begin
          stop      = 1'b1;
          abort_set = (bit_cnt != '0);
        end else if (sample_edge) begin
          shift_en   = 1'b1;
          frame_done = (bit_cnt == LAST_BIT);
        end
      end
      default: ;
    endcase
  end

  // The shift registers still hold the finished word when push_q fires,
  // since the next sample edge is at least four clk_12 cycles away.
  always_ff @(posedge clk_12 or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= '0;
      sh_mosi <= '0;
      sh_miso <= '0;
      bit_cnt <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= frame_done;
      if (start) begin
        mode_q  <= mode;
        sh_mosi <= '0;
        sh_miso <= '0;
        bit_cnt <= '0;
      end else if (stop) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        sh_mosi <= {sh_mosi[FRAME_LEN-2:0], mosi_s};
        sh_miso <= {sh_miso[FRAME_LEN-2:0], miso_s};
        bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_pop       = rd_en & ~empty;
  assign do_push      = push_q & (~full | do_pop);
  assign overflow_set = push_q & full & ~do_pop;

  always_ff @(posedge clk_12) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {sh_mosi, sh_miso};
  end

  always_ff @(posedge clk_12 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_mosi  <= '0;
      dout_miso  <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      dout_valid <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        {dout_mosi, dout_miso} <= mem[rd_ptr[AW-1:0]];
      end
      overflow <= overflow_set | (overflow & ~clr_flags);
      abort    <= abort_set | (abort & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_bus_sniffer.sv
// tb/tb_spi_bus_sniffer.sv - randomized self-checking bench for spi_bus_sniffer
// A word-level queue model predicts FIFO contents and sticky flags.
module tb_spi_bus_sniffer;

  localparam int FL    = 8;
  localparam int DEPTH = 16;
  localparam int CLKP  = 10;
  localparam int HALF  = 40;

  logic          clk_12 = 1'b0;
  logic          rstn = 1'b0;
  logic          sclk = 1'b0;
  logic          MISO = 1'b0;
  logic          MOSI = 1'b0;
  logic          SS = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          rd_en = 1'b0;
  logic          clr_flags = 1'b0;
  logic [FL-1:0] dout_mosi, dout_miso;
  logic          dout_valid, empty, full, overflow, abort;

  spi_bus_sniffer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_12(clk_12), .rstn(rstn), .sclk(sclk), .MISO(MISO), .MOSI(MOSI), .SS(SS),
    .mode(mode), .rd_en(rd_en), .clr_flags(clr_flags),
    .dout_mosi(dout_mosi), .dout_miso(dout_miso), .dout_valid(dout_valid),
    .empty(empty), .full(full), .overflow(overflow), .abort(abort)
  );

  always #(CLKP/2) clk_12 = ~clk_12;

  int             checks = 0;
  int             errors = 0;
  logic [2*FL-1:0] exp_q[$];
  bit             exp_ovf = 0;
  bit             exp_abt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sclk period; CPHA=0 sets data before the leading edge, CPHA=1 on it.
  task automatic xfer_bit(input logic [1:0] m, input logic mo, input logic mi);
    if (!m[0]) begin
      MOSI = mo; MISO = mi;
      #HALF sclk = ~m[1];
      #HALF sclk = m[1];
    end else begin
      sclk = ~m[1]; MOSI = mo; MISO = mi;
      #HALF sclk = m[1];
      #HALF;
    end
  endtask

  // Mode is scrambled after the latch point to show mid-window changes are ignored.
  task automatic ss_begin(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    #(6*CLKP) SS = 1'b0;
    #(6*CLKP) mode = 2'($urandom);
  endtask

  task automatic ss_end();
    #(6*CLKP) SS = 1'b1;
    #(10*CLKP);
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [FL-1:0] mo, input logic [FL-1:0] mi);
    for (int i = FL-1; i >= 0; i--) xfer_bit(m, mo[i], mi[i]);
    if (exp_q.size() < DEPTH) exp_q.push_back({mo, mi});
    else exp_ovf = 1;
  endtask

  task automatic send_partial(input logic [1:0] m, input int n, input logic [FL-1:0] mo, input logic [FL-1:0] mi);
    for (int i = 0; i < n; i++) xfer_bit(m, mo[FL-1-i], mi[FL-1-i]);
  endtask

  task automatic pop_check(input string tag);
    logic [2*FL-1:0] w;
    @(negedge clk_12) rd_en = 1'b1;
    @(negedge clk_12) rd_en = 1'b0;
    w = exp_q.pop_front();
    check_eq({tag, "_valid"}, 64'(dout_valid), 64'd1);
    check_eq({tag, "_mosi"}, 64'(dout_mosi), 64'(w[2*FL-1:FL]));
    check_eq({tag, "_miso"}, 64'(dout_miso), 64'(w[FL-1:0]));
    @(negedge clk_12);
    check_eq({tag, "_pulse"}, 64'(dout_valid), 64'd0);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk_12);
    check_eq({tag, "_empty"}, 64'(empty), 64'(exp_q.size() == 0));
    check_eq({tag, "_full"}, 64'(full), 64'(exp_q.size() == DEPTH));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check_eq({tag, "_abort"}, 64'(abort), 64'(exp_abt));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    @(negedge clk_12);
    check_eq({tag, "_drained"}, 64'(empty), 64'd1);
  endtask

  task automatic clear_flags();
    @(negedge clk_12) clr_flags = 1'b1;
    @(negedge clk_12) clr_flags = 1'b0;
    exp_ovf = 0;
    exp_abt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mosi"}, 64'(dout_mosi), 64'd0);
    check_eq({tag, "_miso"}, 64'(dout_miso), 64'd0);
    check_eq({tag, "_valid"}, 64'(dout_valid), 64'd0);
    check_eq({tag, "_empty"}, 64'(empty), 64'd1);
    check_eq({tag, "_full"}, 64'(full), 64'd0);
    check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
    check_eq({tag, "_abort"}, 64'(abort), 64'd0);
  endtask

  initial begin
    logic [1:0] m;
    int         nf, np;
    #(3*CLKP + 2);
    check_reset_outputs("reset");
    rstn = 1'b1;
    #(10*CLKP);

    ss_begin(2'd0); send_frame(2'd0, 8'hA5, 8'h3C); ss_end();
    check_state("t1");
    drain("t1");

    for (int k = 1; k < 4; k++) begin
      ss_begin(2'(k)); send_frame(2'(k), 8'h81, 8'h7E); ss_end();
      check_state($sformatf("t2m%0d", k));
      drain($sformatf("t2m%0d", k));
    end

    ss_begin(2'd0);
    for (int k = 1; k <= 3; k++) send_frame(2'd0, 8'(k), 8'(8'hF0 | k));
    ss_end();
    check_state("t3");
    drain("t3");

    @(negedge clk_12) rd_en = 1'b1;
    @(negedge clk_12) rd_en = 1'b0;
    check_eq("rd_empty_valid", 64'(dout_valid), 64'd0);

    ss_begin(2'd3);
    for (int k = 0; k < 17; k++) send_frame(2'd3, 8'(k), 8'(~k));
    ss_end();
    check_state("t4");
    drain("t4");
    clear_flags();
    check_state("t4clr");

    ss_begin(2'd1); send_partial(2'd1, 5, 8'hFF, 8'h00); ss_end();
    exp_abt = 1;
    check_state("t5");
    clear_flags();
    check_state("t5clr");
    ss_begin(2'd1); send_frame(2'd1, 8'h96, 8'h69); ss_end();
    check_state("t5next");
    drain("t5next");

    ss_begin(2'd0); send_partial(2'd0, 3, 8'hE0, 8'hE0);
    #(3) rstn = 1'b0;
    #(2*CLKP + 3);
    check_reset_outputs("t6rst");
    rstn = 1'b1;
    ss_end();
    ss_begin(2'd0); send_frame(2'd0, 8'h55, 8'h55); ss_end();
    check_state("t6");
    drain("t6");

    for (int it = 0; it < 12; it++) begin
      m  = 2'($urandom);
      nf = $urandom_range(1, 3);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL-1) : 0;
      ss_begin(m);
      for (int k = 0; k < nf; k++) send_frame(m, 8'($urandom), 8'($urandom));
      if (np > 0) send_partial(m, np, 8'($urandom), 8'($urandom));
      ss_end();
      if (np > 0) exp_abt = 1;
      check_state($sformatf("rnd%0d", it));
      drain($sformatf("rnd%0d", it));
      clear_flags();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
